buffer_transmissao_cubo: RTL and testbench
==========================================

Name: buffer_transmissao_cubo

Overview:
- Parametrised storage and transmit buffer for the identified sticker colours of every cube face.
- Generalises the single-face 3x3 colour store to N_FACES faces of GRID x GRID stickers.
- Adds per-face completion tracking and a byte-stream transmitter with a raw mode and an ASCII mode.
- Sits between the colour-identification stage, which performs the writes, and the serial transmitter, which consumes bytes over a valid/ready handshake.

Parameters:
N_FACES, 6, number of faces stored
GRID, 3, stickers per row/column of one face
S_COR, 3, colour code width in bits
W_FACE, 3, face index width
W_IDX, 2, row/column index width
TERMINADOR, 8'h0A, byte appended after the last sticker in ASCII mode

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset (asserted when 0)
we_cor  in  1  write strobe for one sticker
face  in  W_FACE  face index of the write
linha  in  W_IDX  row index of the write
coluna  in  W_IDX  column index of the write
cor  in  S_COR  colour code to store
limpa  in  1  synchronous clear of contents and completion flags
iniciar_envio  in  1  start transmission of all faces
modo_ascii  in  1  1 = ASCII letters plus terminator; 0 = raw codes
tx_dados  out  8  byte offered to the serial transmitter
tx_valido  out  1  tx_dados is valid
tx_pronto  in  1  transmitter accepts the byte this cycle
faces_completas  out  N_FACES  bit f = 1 when all GRID*GRID stickers of face f have been written
ocupado  out  1  transmission in progress
pronto  out  1  one-cycle pulse when transmission ends
erro_escrita  out  1  one-cycle pulse when a write is rejected

Behaviour:
- Reset (reset=0, asynchronous): storage=0, written-position bitmaps=0, FSM=OCIOSO, tx_dados=0, tx_valido=0, ocupado=0, pronto=0, erro_escrita=0, faces_completas=0.
- Write: accepted on the rising edge when we_cor=1, FSM=OCIOSO, face<N_FACES, linha<GRID and coluna<GRID.
  - Stores cor at [face][linha][coluna] and sets that position's written bit.
  - Rewriting an already written position updates the colour; flags are unchanged.
- Rejected write: out-of-range address, or FSM not OCIOSO.
  - Storage and flags stay unchanged.
  - erro_escrita pulses high in the next cycle.
- faces_completas[f]: registered AND of face f's written bits; updates the cycle after the completing write.
- limpa=1 in OCIOSO clears storage and bitmaps in one cycle. limpa is ignored outside OCIOSO. If limpa and we_cor are asserted in the same cycle, limpa wins and the write is dropped without an error pulse.
- Transmit order: face 0..N_FACES-1, then row 0..GRID-1, then column 0..GRID-1. That gives N_FACES*GRID*GRID bytes, plus TERMINADOR in ASCII mode.
- ASCII map: 0->'W'(57h), 1->'Y'(59h), 2->'R'(52h), 3->'O'(4Fh), 4->'G'(47h), 5->'B'(42h), other codes->'?'(3Fh).
- Raw mode byte: zero-extended cor.
- modo_ascii is sampled only when iniciar_envio is accepted.
- FSM states:
  - OCIOSO: iniciar_envio=1 -> CARREGA; counters face/row/col=0; latch the mode; ocupado=1 from the next cycle.
  - CARREGA: register tx_dados from the current position -> ENVIA. The first tx_valido appears 2 cycles after iniciar_envio.
  - ENVIA: tx_valido=1 and tx_dados held stable until tx_pronto=1. On handshake, tx_valido drops the next cycle. Then:
    - last sticker and ASCII mode -> TERM
    - last sticker and raw mode -> FIM
    - otherwise advance the counters (col wraps into row, row wraps into face) -> CARREGA.
  - TERM: tx_dados=TERMINADOR, tx_valido=1 until handshake -> FIM.
  - FIM: pronto=1 for one cycle; ocupado=0 -> OCIOSO.
- Handshake: tx_pronto is ignored while tx_valido=0. There is no timeout.
- iniciar_envio while not OCIOSO is ignored.
- Reset mid-transmission aborts immediately. No pronto pulse is generated and contents are cleared.
- Each byte transfer costs at least 2 cycles (CARREGA plus ENVIA). With tx_pronto tied high, a default ASCII run takes 2*55 cycles, plus 1 for FIM.

Test Plan:
- Reset with buffer holding data, then release -> all outputs 0; a read-back transmission in raw mode yields 54 bytes of 00h.
- Write all 9 stickers of face 2 with cor=1 -> faces_completas=6'b000100 one cycle after the 9th write; other bits stay 0. Writing linha=3 -> erro_escrita pulse; flags unchanged.
- Fill faces 0..5 with codes 0..5, ASCII mode, tx_pronto tied 1 -> bytes: 9x'W', 9x'Y', 9x'R', 9x'O', 9x'G', 9x'B', then 0Ah; pronto pulses once; ocupado high throughout.
- Raw mode with tx_pronto stalled low for 5 cycles on byte 10 -> tx_valido and tx_dados stable during the stall; no bytes lost or duplicated; 54 bytes total; no terminator.
- we_cor during transmission -> erro_escrita pulse; transmitted stream unchanged. iniciar_envio during transmission -> ignored.
- Assert reset=0 at byte 20 -> tx_valido=0 immediately; no pronto; a subsequent transmission sends all zero codes.

Source files
------------

// File: rtl/buffer_transmissao_cubo_if.sv
// Byte stream between the cube buffer and the serial transmitter.
// The master offers tx_dados/tx_valido and the slave accepts with tx_pronto.
interface buffer_transmissao_cubo_if;
    logic [7:0] tx_dados;
    logic       tx_valido;
    logic       tx_pronto;

    modport master (output tx_dados, output tx_valido, input tx_pronto);
    modport slave  (input tx_dados, input tx_valido, output tx_pronto);
endinterface

// File: rtl/buffer_transmissao_cubo.sv
// Colour store for N_FACES faces of GRID x GRID stickers, with per-face completion
// flags and a byte transmitter that sends raw codes or ASCII letters plus a terminator.
module buffer_transmissao_cubo #(
    parameter int         N_FACES    = 6,
    parameter int         GRID       = 3,
    parameter int         S_COR      = 3,
    parameter int         W_FACE     = 3,
    parameter int         W_IDX      = 2,
    parameter logic [7:0] TERMINADOR = 8'h0A
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   we_cor,
    input  logic [W_FACE-1:0]      face,
    input  logic [W_IDX-1:0]       linha,
    input  logic [W_IDX-1:0]       coluna,
    input  logic [S_COR-1:0]       cor,
    input  logic                   limpa,
    input  logic                   iniciar_envio,
    input  logic                   modo_ascii,
    buffer_transmissao_cubo_if.master tx,
    output logic [N_FACES-1:0]     faces_completas,
    output logic                   ocupado,
    output logic                   pronto,
    output logic                   erro_escrita
);

    typedef enum logic [2:0] {OCIOSO, CARREGA, ENVIA, TERM, FIM} estado_t;

    localparam int                N_POS    = GRID * GRID;
    localparam logic [W_FACE-1:0] ULT_FACE = W_FACE'(N_FACES - 1);
    localparam logic [W_IDX-1:0]  ULT_IDX  = W_IDX'(GRID - 1);

    estado_t                   estado_q, estado_d;
    logic [S_COR-1:0]          mem_q [N_FACES][GRID][GRID];
    logic [S_COR-1:0]          mem_d [N_FACES][GRID][GRID];
    logic [N_FACES-1:0][N_POS-1:0] escrito_q, escrito_d;
    logic [N_FACES-1:0]        faces_q, faces_d;
    logic [W_FACE-1:0]         face_q, face_d;
    logic [W_IDX-1:0]          lin_q, lin_d, col_q, col_d;
    logic                      modo_q, modo_d;
    logic [7:0]                tx_dados_q, tx_dados_d;
    logic                      tx_valido_q, tx_valido_d;
    logic                      ocupado_q, ocupado_d;
    logic                      pronto_q, pronto_d;
    logic                      erro_q, erro_d;

    logic                      ultimo;
    logic                      endereco_ok;
    logic [S_COR-1:0]          cor_atual;

    function automatic logic [7:0] para_ascii(input logic [S_COR-1:0] c);
        case (int'(c))
            0:       return 8'h57;
            1:       return 8'h59;
            2:       return 8'h52;
            3:       return 8'h4F;
            4:       return 8'h47;
            5:       return 8'h42;
            default: return 8'h3F;
        endcase
    endfunction

    assign ultimo      = (face_q == ULT_FACE) && (lin_q == ULT_IDX) && (col_q == ULT_IDX);
    assign endereco_ok = (int'(face) < N_FACES) && (int'(linha) < GRID) && (int'(coluna) < GRID);
    assign cor_atual   = mem_q[face_q][lin_q][col_q];

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        estado_d    = estado_q;
        mem_d       = mem_q;
        escrito_d   = escrito_q;
        face_d      = face_q;
        lin_d       = lin_q;
        col_d       = col_q;
        modo_d      = modo_q;
        tx_dados_d  = tx_dados_q;
        tx_valido_d = tx_valido_q;
        ocupado_d   = ocupado_q;
        pronto_d    = 1'b0;
        erro_d      = 1'b0;

        if (estado_q != OCIOSO && we_cor) erro_d = 1'b1;

        case (estado_q)
            OCIOSO: begin
                // A clear takes priority over a simultaneous write and silently drops it.
                if (limpa) begin
                    mem_d     = '{default: '0};
                    escrito_d = '0;
                end else if (we_cor) begin
                    if (endereco_ok) begin
                        mem_d[face][linha][coluna] = cor;
                        escrito_d[face][int'(linha) * GRID + int'(coluna)] = 1'b1;
                    end else begin
                        erro_d = 1'b1;
                    end
                end
                if (iniciar_envio) begin
                    estado_d  = CARREGA;
                    face_d    = '0;
                    lin_d     = '0;
                    col_d     = '0;
                    modo_d    = modo_ascii;
                    ocupado_d = 1'b1;
                end
            end
            CARREGA: begin
                tx_dados_d  = modo_q ? para_ascii(cor_atual) : 8'(cor_atual);
                tx_valido_d = 1'b1;
                estado_d    = ENVIA;
            end
            ENVIA: begin
                if (tx.tx_pronto) begin
                    tx_valido_d = 1'b0;
                    if (ultimo) begin
                        if (modo_q) begin
                            estado_d = TERM;
                        end else begin
                            estado_d  = FIM;
                            pronto_d  = 1'b1;
                            ocupado_d = 1'b0;
                        end
                    end else begin
                        estado_d = CARREGA;
                        if (col_q == ULT_IDX) begin
                            col_d = '0;
                            if (lin_q == ULT_IDX) begin
                                lin_d  = '0;
                                face_d = face_q + W_FACE'(1);
                            end else begin
                                lin_d = lin_q + W_IDX'(1);
                            end
                        end else begin
                            col_d = col_q + W_IDX'(1);
                        end
                    end
                end
            end
            TERM: begin
                // First cycle loads the terminator, then it is held until accepted.
                if (!tx_valido_q) begin
                    tx_dados_d  = TERMINADOR;
                    tx_valido_d = 1'b1;
                end else if (tx.tx_pronto) begin
                    tx_valido_d = 1'b0;
                    estado_d    = FIM;
                    pronto_d    = 1'b1;
                    ocupado_d   = 1'b0;
                end
            end
            FIM:     estado_d = OCIOSO;
            default: estado_d = OCIOSO;
        endcase

        for (int f = 0; f < N_FACES; f++) faces_d[f] = &escrito_d[f];
    end

    // NOTE: the sticker store is reset with everything else because a reset must clear contents.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado_q    <= OCIOSO;
            mem_q       <= '{default: '0};
            escrito_q   <= '0;
            faces_q     <= '0;
            face_q      <= '0;
            lin_q       <= '0;
            col_q       <= '0;
            modo_q      <= 1'b0;
            tx_dados_q  <= '0;
            tx_valido_q <= 1'b0;
            ocupado_q   <= 1'b0;
            pronto_q    <= 1'b0;
            erro_q      <= 1'b0;
        end else begin
            estado_q    <= estado_d;
            mem_q       <= mem_d;
            escrito_q   <= escrito_d;
            faces_q     <= faces_d;
            face_q      <= face_d;
            lin_q       <= lin_d;
            col_q       <= col_d;
            modo_q      <= modo_d;
            tx_dados_q  <= tx_dados_d;
            tx_valido_q <= tx_valido_d;
            ocupado_q   <= ocupado_d;
            pronto_q    <= pronto_d;
            erro_q      <= erro_d;
        end
    end

    assign tx.tx_dados     = tx_dados_q;
    assign tx.tx_valido    = tx_valido_q;
    assign faces_completas = faces_q;
    assign ocupado         = ocupado_q;
    assign pronto          = pronto_q;
    assign erro_escrita    = erro_q;

endmodule

// File: tb/tb_buffer_transmissao_cubo.sv
// Directed sequence with randomized colours and receiver back-pressure, checked
// against a sticker-array model and an expected byte queue.
module tb_buffer_transmissao_cubo;

    logic       clock;
    logic       reset;
    logic       we_cor, limpa, iniciar_envio, modo_ascii;
    logic [2:0] face;
    logic [1:0] linha, coluna;
    logic [2:0] cor;
    logic [5:0] faces_completas;
    logic       ocupado, pronto, erro_escrita;

    int checks;
    int errors;

    logic [2:0] model [6][3][3];
    bit   [8:0] wrt   [6];
    string      letters;

    buffer_transmissao_cubo_if tx_if ();

    buffer_transmissao_cubo dut (
        .clock           (clock),
        .reset           (reset),
        .we_cor          (we_cor),
        .face            (face),
        .linha           (linha),
        .coluna          (coluna),
        .cor             (cor),
        .limpa           (limpa),
        .iniciar_envio   (iniciar_envio),
        .modo_ascii      (modo_ascii),
        .tx              (tx_if),
        .faces_completas (faces_completas),
        .ocupado         (ocupado),
        .pronto          (pronto),
        .erro_escrita    (erro_escrita)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] ascii_of(input logic [2:0] c);
        if (c < 3'd6) return letters[int'(c)];
        return 8'h3F;
    endfunction

    function automatic logic [5:0] exp_faces();
        logic [5:0] r;
        for (int f = 0; f < 6; f++) r[f] = &wrt[f];
        return r;
    endfunction

    task automatic clear_model();
        for (int f = 0; f < 6; f++) begin
            wrt[f] = '0;
            for (int l = 0; l < 3; l++)
                for (int c = 0; c < 3; c++) model[f][l][c] = 3'd0;
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_dados"},   tx_if.tx_dados, 8'h00);
        check({tag, "_valido"},  tx_if.tx_valido, 1'b0);
        check({tag, "_ocupado"}, ocupado, 1'b0);
        check({tag, "_pronto"},  pronto, 1'b0);
        check({tag, "_erro"},    erro_escrita, 1'b0);
        check({tag, "_faces"},   faces_completas, 6'h00);
    endtask

    // One write cycle; the error flag and completion flags are visible at the next negedge.
    task automatic wr(input int f, input int l, input int c, input logic [2:0] cr, input bit exp_err);
        we_cor = 1'b1;
        face   = 3'(f);
        linha  = 2'(l);
        coluna = 2'(c);
        cor    = cr;
        @(negedge clock);
        we_cor = 1'b0;
        if (!exp_err) begin
            model[f][l][c] = cr;
            wrt[f][l * 3 + c] = 1'b1;
        end
        check("erro_escrita", erro_escrita, exp_err);
        check("faces_completas", faces_completas, exp_faces());
    endtask

    task automatic run_tx(input bit ascii, input bit rnd_pronto, input int stall_at,
                          input bit disturb, input int abort_at);
        logic [7:0] exp_q [$];
        logic [7:0] rx_q [$];
        int   cycles = 0, pronto_cnt = 0, busy = 0, idle_early = 0, post = 0;
        int   stall_left = 5;
        bit   prev_stalled = 1'b0, done = 1'b0, aborted = 1'b0;
        logic [7:0] prev_data = 8'h00;
        int   n;

        for (int f = 0; f < 6; f++)
            for (int l = 0; l < 3; l++)
                for (int c = 0; c < 3; c++)
                    exp_q.push_back(ascii ? ascii_of(model[f][l][c]) : {5'b0, model[f][l][c]});
        if (ascii) exp_q.push_back(8'h0A);

        modo_ascii    = ascii;
        iniciar_envio = 1'b1;
        @(negedge clock);
        iniciar_envio = 1'b0;
        modo_ascii    = ~ascii;

        while (!done && cycles < 3000) begin
            cycles++;
            if (abort_at >= 0 && rx_q.size() == abort_at) begin
                reset = 1'b0;
                tx_if.tx_pronto = 1'b0;
                #1;
                check("abort_valido", tx_if.tx_valido, 1'b0);
                check("abort_ocupado", ocupado, 1'b0);
                check("abort_pronto", pronto, 1'b0);
                clear_model();
                @(negedge clock);
                reset = 1'b1;
                aborted = 1'b1;
                break;
            end
            if (cycles == 1) check("lat_valido_low", tx_if.tx_valido, 1'b0);
            if (cycles == 2) check("lat_valido_high", tx_if.tx_valido, 1'b1);
            if (prev_stalled) begin
                check("hold_valido", tx_if.tx_valido, 1'b1);
                check("hold_dados", tx_if.tx_dados, prev_data);
            end
            if (pronto) pronto_cnt++;
            if (ocupado) busy++;
            else if (pronto_cnt == 0) idle_early++;
            if (pronto_cnt > 0) begin
                post++;
                if (post > 3) done = 1'b1;
            end

            if (disturb && cycles == 8) begin
                check("erro_busy_write", erro_escrita, 1'b1);
                we_cor = 1'b0; iniciar_envio = 1'b0; limpa = 1'b0;
            end
            if (disturb && cycles == 7) begin
                we_cor = 1'b1;
                face   = 3'($urandom_range(0, 5));
                linha  = 2'($urandom_range(0, 2));
                coluna = 2'($urandom_range(0, 2));
                cor    = 3'($urandom_range(0, 7));
                iniciar_envio = 1'b1;
                limpa  = 1'b1;
            end

            if (stall_at >= 0 && rx_q.size() == stall_at && tx_if.tx_valido && stall_left > 0) begin
                tx_if.tx_pronto = 1'b0;
                stall_left--;
            end else begin
                tx_if.tx_pronto = rnd_pronto ? ($urandom_range(0, 3) != 0) : 1'b1;
            end
            prev_stalled = tx_if.tx_valido && !tx_if.tx_pronto;
            prev_data    = tx_if.tx_dados;
            if (tx_if.tx_valido && tx_if.tx_pronto) rx_q.push_back(tx_if.tx_dados);
            @(negedge clock);
        end
        tx_if.tx_pronto = 1'b0;
        if (aborted) return;

        if (!done) check("tx_timeout", 1'b0, 1'b1);
        check("n_bytes", rx_q.size(), exp_q.size());
        n = (rx_q.size() < exp_q.size()) ? rx_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) check($sformatf("byte%0d", i), rx_q[i], exp_q[i]);
        check("pronto_count", pronto_cnt, 1);
        check("ocupado_throughout", idle_early, 0);
        check("end_ocupado", ocupado, 1'b0);
        check("end_valido", tx_if.tx_valido, 1'b0);
        if (!rnd_pronto)
            check("busy_cycles", busy, 2 * exp_q.size() + ((stall_at >= 0) ? 5 : 0));
    endtask

    initial begin
        checks = 0; errors = 0;
        letters = "WYROGB";
        reset = 1'b0; we_cor = 1'b0; limpa = 1'b0; iniciar_envio = 1'b0; modo_ascii = 1'b0;
        face = '0; linha = '0; coluna = '0; cor = '0;
        tx_if.tx_pronto = 1'b0;
        clear_model();
        repeat (3) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);

        // Reset while holding data clears everything
        for (int i = 0; i < 20; i++)
            wr($urandom_range(0, 5), $urandom_range(0, 2), $urandom_range(0, 2),
               3'($urandom_range(1, 7)), 1'b0);
        reset = 1'b0;
        #1;
        check_idle("in_reset");
        clear_model();
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check_idle("post_reset");
        run_tx(1'b0, 1'b0, -1, 1'b0, -1);

        // Face 2 completion and rejected writes
        for (int p = 0; p < 9; p++) wr(2, p / 3, p % 3, 3'd1, 1'b0);
        check("face2_complete", faces_completas, 6'b000100);
        wr(2, 3, 0, 3'd5, 1'b1);
        wr(2, 0, 3, 3'd5, 1'b1);
        wr(6, 0, 0, 3'd5, 1'b1);
        wr(7, 1, 1, 3'd5, 1'b1);
        @(negedge clock);
        check("erro_drop", erro_escrita, 1'b0);
        wr(2, 1, 1, 3'd4, 1'b0);
        check("face2_rewrite", faces_completas, 6'b000100);

        // Clear wins over a simultaneous write, with no error
        limpa = 1'b1; we_cor = 1'b1; face = 3'd2; linha = 2'd0; coluna = 2'd0; cor = 3'd6;
        @(negedge clock);
        limpa = 1'b0; we_cor = 1'b0;
        clear_model();
        check("limpa_no_erro", erro_escrita, 1'b0);
        check("limpa_faces", faces_completas, 6'h00);

        // Partial random fill, raw mode with a stall on byte 10 and disturbances mid-run
        for (int f = 0; f < 6; f++)
            for (int l = 0; l < 3; l++)
                for (int c = 0; c < 3; c++) begin
                    if ($urandom_range(0, 3) != 0) wr(f, l, c, 3'($urandom_range(0, 7)), 1'b0);
                    if ($urandom_range(0, 7) == 0) wr(6 + $urandom_range(0, 1), l, c, 3'd3, 1'b1);
                end
        run_tx(1'b0, 1'b0, 10, 1'b1, -1);

        // Faces 0..5 with codes 0..5, ASCII, receiver always ready
        for (int f = 0; f < 6; f++)
            for (int l = 0; l < 3; l++)
                for (int c = 0; c < 3; c++) wr(f, l, c, 3'(f), 1'b0);
        check("all_faces", faces_completas, 6'h3F);
        run_tx(1'b1, 1'b0, -1, 1'b0, -1);

        // Random codes (including unmapped ones), ASCII, random back-pressure
        for (int f = 0; f < 6; f++)
            for (int l = 0; l < 3; l++)
                for (int c = 0; c < 3; c++) wr(f, l, c, 3'($urandom_range(0, 7)), 1'b0);
        run_tx(1'b1, 1'b1, -1, 1'b0, -1);

        // Reset at byte 20 aborts; the next run sends zeros
        run_tx(1'b1, 1'b0, -1, 1'b0, 20);
        @(negedge clock);
        check_idle("after_abort");
        run_tx(1'b0, 1'b1, -1, 1'b0, -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
